// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : ALUSel operation codes for the shared ALU and the muldiv_seq FSM
//           state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_scp.sv
// ============================================================================
// Module  : ALU_SCP
// Brief   : Combinational execute-stage ALU, shared with the multi-cycle
//           multiply/divide sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ALU_SCP
  import alu_pkg::*;
#(
  parameter int WL = 33
) (
  input  logic [3:0]    ALUSel,
  input  logic [WL-1:0] ALUIN1,
  input  logic [WL-1:0] ALUIN2,
  output logic [WL-1:0] ALUOut,
  output logic          zero,
  output logic          OVF_F
);

  logic [WL-1:0] w_sum;
  logic [WL-1:0] w_diff;

  assign w_sum  = ALUIN1 + ALUIN2;
  assign w_diff = ALUIN1 - ALUIN2;

  always_comb begin
    ALUOut = '0;
    OVF_F  = 1'b0;
    case (ALUSel)
      ALU_ADD: begin
        ALUOut = w_sum;
        OVF_F  = (ALUIN1[WL-1] == ALUIN2[WL-1]) && (w_sum[WL-1] != ALUIN1[WL-1]);
      end
      ALU_SUB: begin
        ALUOut = w_diff;
        OVF_F  = (ALUIN1[WL-1] != ALUIN2[WL-1]) && (w_diff[WL-1] != ALUIN1[WL-1]);
      end
      ALU_AND: ALUOut = ALUIN1 & ALUIN2;
      ALU_OR:  ALUOut = ALUIN1 | ALUIN2;
      ALU_XOR: ALUOut = ALUIN1 ^ ALUIN2;
      ALU_NOR: ALUOut = ~(ALUIN1 | ALUIN2);
      ALU_SLT: ALUOut = {{(WL-1){1'b0}}, ($signed(ALUIN1) < $signed(ALUIN2))};
      ALU_SLL: ALUOut = ALUIN1 << ALUIN2;
      ALU_SRL: ALUOut = ALUIN1 >> ALUIN2;
      ALU_SRA: ALUOut = $unsigned($signed(ALUIN1) >>> ALUIN2);
      default: ALUOut = '0;
    endcase
  end

  assign zero = (ALUOut == '0);

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module  : muldiv_seq
// Brief   : Multi-cycle MULTU/DIVU sequencer borrowing the shared ALU for
//           shift-add multiply and restoring divide; owns HI/LO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op_div,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic [3:0]    alu_sel,
  output logic [DW:0]   alu_in1,
  output logic [DW:0]   alu_in2,
  input  logic [DW:0]   alu_out,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(DW) + 1;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_opnd;
  logic [CW-1:0] r_count;
  logic          r_op_div;
  logic          r_div_zero;

  logic          w_accept;
  logic          w_last;
  logic          w_take;
  logic [DW:0]   w_sh;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_count == CW'(DW - 1));
  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign w_sh     = {r_hi, r_lo[DW-1]};
  assign w_take   = w_sh[DW] | ~alu_out[DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    alu_sel = ALU_ADD;
    alu_in1 = '0;
    alu_in2 = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (op_div && (opb == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_op_div) begin
          alu_sel = ALU_SUB;
          alu_in1 = w_sh;
          alu_in2 = {1'b0, r_opnd};
        end else begin
          alu_sel = ALU_ADD;
          alu_in1 = {1'b0, r_hi};
          alu_in2 = r_lo[0] ? {1'b0, r_opnd} : '0;
        end
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_count    <= '0;
      r_op_div   <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_op_div   <= op_div;
      r_count    <= '0;
      r_div_zero <= 1'b0;
      if (op_div) begin
        r_opnd <= opb;
        if (opb == '0) begin
          r_hi       <= opa;
          r_lo       <= '1;
          r_div_zero <= 1'b1;
        end else begin
          r_hi <= '0;
          r_lo <= opa;
        end
      end else begin
        r_hi   <= '0;
        r_lo   <= opb;
        r_opnd <= opa;
      end
    end else if (r_state == RUN) begin
      r_count <= r_count + CW'(1);
      if (r_op_div) begin
        r_hi <= w_take ? alu_out[DW-1:0] : w_sh[DW-1:0];
        r_lo <= {r_lo[DW-2:0], w_take};
      end else begin
        // Sum carry-out becomes the new HI MSB; the dropped bit enters LO.
        r_hi <= alu_out[DW:1];
        r_lo <= {alu_out[0], r_lo[DW-1:1]};
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module  : tb_muldiv_seq
// Brief   : Self-checking bench for muldiv_seq wired to the shared ALU_SCP.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op_div = 1'b0;
  logic [DW-1:0] opa = '0;
  logic [DW-1:0] opb = '0;
  logic [3:0]    alu_sel;
  logic [DW:0]   alu_in1;
  logic [DW:0]   alu_in2;
  logic [DW:0]   alu_out;
  logic          alu_zero;
  logic          alu_ovf;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.DW(DW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .opa(opa), .opb(opb),
    .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  ALU_SCP #(.WL(DW + 1)) u_alu (
    .ALUSel(alu_sel), .ALUIN1(alu_in1), .ALUIN2(alu_in2),
    .ALUOut(alu_out), .zero(alu_zero), .OVF_F(alu_ovf)
  );

  typedef struct {
    logic          d;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_hi;
    logic [DW-1:0] exp_lo;
    logic          exp_dz;
    int            exp_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered #1 after a rising edge with the DUT idle; returns in the same phase.
  task automatic run_op(input logic d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int glitch, input logic hold_done,
                        output logic [DW-1:0] h, output logic [DW-1:0] l,
                        output logic z, output int cyc, output int bcnt);
    op_div = d; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom; op_div = ~d;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 60) begin
      if (busy) bcnt++;
      if (cyc == glitch) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    h = hi; l = lo; z = div_zero;
    chk("alu_in_idle", {alu_in1, alu_in2}, '0);
    if (hold_done) begin
      start = 1'b1; op_div = 1'b0; opa = 3; opb = 4;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", {busy, done}, 0);
  endtask

  logic [DW-1:0] r_h, r_l;
  logic          r_z;
  int            r_cyc, r_bcnt, dcount;
  logic [DW-1:0] ra, rb;
  logic          rd;
  logic [63:0]   exp_pair;

  initial begin
    vecs[0] = '{1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[2] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 33};
    vecs[4] = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5] = '{1'b0, 32'd0, 32'd12345, 32'd0, 32'd0, 1'b0, 33};
    vecs[6] = '{1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33};
    vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 33};
    vecs[8] = '{1'b0, 32'h80000000, 32'd2, 32'd1, 32'd0, 1'b0, 33};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_flags", {busy, done, div_zero}, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_alu_in", {alu_in1, alu_in2}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, 0, 1'b0, r_h, r_l, r_z, r_cyc, r_bcnt);
      chk($sformatf("vec%0d_hi", i), r_h, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), r_l, vecs[i].exp_lo);
      chk($sformatf("vec%0d_dz", i), r_z, vecs[i].exp_dz);
      chk($sformatf("vec%0d_cyc", i), r_cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_busy", i), r_bcnt, vecs[i].exp_cyc == 33 ? 32 : 0);
    end

    // div_zero stays set through idle cycles, then clears on the next start.
    run_op(1'b1, 32'd9, 32'd0, 0, 1'b0, r_h, r_l, r_z, r_cyc, r_bcnt);
    repeat (3) @(posedge clk);
    #1;
    chk("dz_sticky", {div_zero, hi, lo}, {1'b1, 32'd9, 32'hFFFFFFFF});
    op_div = 1'b0; opa = 2; opb = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz_clear_on_start", {div_zero, busy}, 2'b01);
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
    end
    chk("after_clear_lo", lo, 6);
    @(posedge clk); #1;

    // Start pulses during RUN and while done is high must be dropped.
    run_op(1'b0, 32'd1000, 32'd3, 5, 1'b1, r_h, r_l, r_z, r_cyc, r_bcnt);
    chk("glitch_result", {r_h, r_l}, 64'd3000);
    chk("glitch_cyc", r_cyc, 33);
    run_op(1'b1, 32'd1000, 32'd3, 20, 1'b0, r_h, r_l, r_z, r_cyc, r_bcnt);
    chk("glitch_div", {r_h, r_l}, {32'd1, 32'd333});

    // Asynchronous reset in the middle of RUN.
    op_div = 1'b0; opa = 7; opb = 6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_state", {busy, done, div_zero}, 0);
    chk("midrst_hilo", {hi, lo}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    run_op(1'b1, 32'd100, 32'd7, 0, 1'b0, r_h, r_l, r_z, r_cyc, r_bcnt);
    chk("midrst_next_op", {r_h, r_l}, {32'd2, 32'd14});

    // Randomized operands against plain arithmetic.
    for (int n = 0; n < 1000; n++) begin
      rd = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      if (rd && rb == 0) exp_pair = {ra, 32'hFFFFFFFF};
      else if (rd)       exp_pair = {ra % rb, ra / rb};
      else               exp_pair = 64'(ra) * 64'(rb);
      run_op(rd, ra, rb, 0, 1'b0, r_h, r_l, r_z, r_cyc, r_bcnt);
      chk($sformatf("rand%0d_result", n), {r_h, r_l}, exp_pair);
      chk($sformatf("rand%0d_dz", n), r_z, (rd && rb == 0));
      chk($sformatf("rand%0d_cyc", n), r_cyc, (rd && rb == 0) ? 1 : DW + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
